// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sequencing set/reset commands onto a bank of SR status bits.
// Optional illegal-command counter enabled by defining SR_BANK_ERRCNT_EN.
//
// state  | meaning
// IDLE   | no candidate at the last edge, nothing granted
// GRANT  | a command was granted and applied at the last edge
// PRESET | bank was preset to all ones at the last edge
module sr_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
   parameter int AW    = 3
) (
   input  logic               CLK,
   input  logic               CLR,
   input  logic               PR,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    S,
   input  logic [NREQ-1:0]    R,
   input  logic [NREQ*AW-1:0] addr,
   output logic [NREQ-1:0]    gnt,
   output logic [NBITS-1:0]   Q,
   output logic               busy,
   output logic               illegal
`ifdef SR_BANK_ERRCNT_EN
   ,
   output logic [7:0]         err_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, PRESET} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic [NREQ-1:0]   gnt_q, gnt_nxt;
   logic [NREQ-1:0]   cand;
   logic [NBITS-1:0]  q_nxt;
   logic              busy_nxt, illegal_nxt;
   logic              hi_found, lo_found;
   logic [PW-1:0]     hi_w, lo_w, win;
   logic [AW-1:0]     addr_w;
   logic              s_w, r_w;

   assign gnt = (state == GRANT) ? gnt_q : '0;

   always_comb begin
      cand     = req & ~gnt;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_w     = '0;
      lo_w     = '0;
      // descending scan leaves the lowest index at/above ptr and the lowest below it
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            if (i >= int'(ptr)) begin
               hi_found = 1'b1;
               hi_w     = PW'(i);
            end else begin
               lo_found = 1'b1;
               lo_w     = PW'(i);
            end
         end
      end
      win = hi_found ? hi_w : lo_w;

      addr_w = '0;
      s_w    = 1'b0;
      r_w    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == win) begin
            addr_w = addr[i*AW +: AW];
            s_w    = S[i];
            r_w    = R[i];
         end
      end
   end

   always_comb begin
      state_nxt   = IDLE;
      gnt_nxt     = '0;
      q_nxt       = Q;
      ptr_nxt     = ptr;
      illegal_nxt = 1'b0;
      busy_nxt    = |cand;
      if (CLR) begin
         q_nxt    = '0;
         ptr_nxt  = '0;
         busy_nxt = 1'b0;
      end else if (PR) begin
         state_nxt = PRESET;
         q_nxt     = '1;
      end else if (hi_found || lo_found) begin
         state_nxt    = GRANT;
         gnt_nxt[win] = 1'b1;
         ptr_nxt      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
         // out-of-range targets still consume the grant but touch nothing
         if (int'(addr_w) < NBITS) begin
            if (s_w && r_w)
               illegal_nxt = 1'b1;
            else if (s_w)
               q_nxt[addr_w] = 1'b1;
            else if (r_w)
               q_nxt[addr_w] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= IDLE;
         gnt_q   <= '0;
         Q       <= '0;
         ptr     <= '0;
         busy    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt_q   <= gnt_nxt;
         Q       <= q_nxt;
         ptr     <= ptr_nxt;
         busy    <= busy_nxt;
         illegal <= illegal_nxt;
      end
   end

`ifdef SR_BANK_ERRCNT_EN
   always_ff @(posedge CLK) begin
      if (CLR)
         err_cnt <= '0;
      else if (illegal_nxt && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter with hand-computed expectations.
// Define SR_BANK_ERRCNT_EN to also check the illegal-command counter.
module tb_sr_bank_arbiter;

   logic        CLK = 1'b0;
   logic        CLR, PR;
   logic [3:0]  req, S, R;
   logic [11:0] addr;
   logic [3:0]  gnt;
   logic [7:0]  Q;
   logic        busy, illegal;
`ifdef SR_BANK_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   sr_bank_arbiter #(.NREQ(4), .NBITS(8), .AW(3)) dut (
      .CLK(CLK), .CLR(CLR), .PR(PR), .req(req), .S(S), .R(R), .addr(addr),
      .gnt(gnt), .Q(Q), .busy(busy), .illegal(illegal)
`ifdef SR_BANK_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_addr(input logic [2:0] a3, a2, a1, a0);
      addr = {a3, a2, a1, a0};
   endtask

   initial begin
      CLR = 1'b1; PR = 1'b0; req = 4'hF; S = 4'h0; R = 4'h0; addr = '0;

      // 1: reset dominates pending requests
      step(); step();
      check("rst_q", 32'(Q), 32'h00);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ill", 32'(illegal), 32'h0);

      // 2: set then reset bit 3 from requester 0
      CLR = 1'b0; req = 4'b0001; S = 4'b0001; set_addr(0, 0, 0, 3);
      step();
      check("t2_gnt", 32'(gnt), 32'h1);
      check("t2_q_set", 32'(Q), 32'h08);
      check("t2_busy", 32'(busy), 32'h1);
      S = 4'b0000; R = 4'b0001;
      step();
      check("t2_mask_gnt", 32'(gnt), 32'h0);
      check("t2_mask_q", 32'(Q), 32'h08);
      step();
      check("t2_gnt2", 32'(gnt), 32'h1);
      check("t2_q_clr", 32'(Q), 32'h00);
      req = 4'b0000; R = 4'b0000;
      step();
      check("t2_idle_busy", 32'(busy), 32'h0);

      // 3: all four requesters, rotation from ptr 0
      CLR = 1'b1; step(); CLR = 1'b0;
      req = 4'hF; S = 4'hF; R = 4'h0; set_addr(3, 2, 1, 0);
      step(); check("t3_g0", 32'(gnt), 32'b0001); check("t3_q0", 32'(Q), 32'h01); req = req & ~4'b0001;
      step(); check("t3_g1", 32'(gnt), 32'b0010); check("t3_q1", 32'(Q), 32'h03); req = req & ~4'b0010;
      step(); check("t3_g2", 32'(gnt), 32'b0100); check("t3_q2", 32'(Q), 32'h07); req = req & ~4'b0100;
      step(); check("t3_g3", 32'(gnt), 32'b1000); check("t3_q3", 32'(Q), 32'h0F); req = 4'h0;
      step(); check("t3_done_gnt", 32'(gnt), 32'h0);

      // 4: illegal S=R=1 from requester 2 on bit 5 (Q=0x20 first)
      CLR = 1'b1; step(); CLR = 1'b0;
      req = 4'b0001; S = 4'b0001; R = 4'b0000; set_addr(0, 0, 0, 5);
      step(); check("t4_pre_q", 32'(Q), 32'h20); req = 4'b0000;
      step();
      req = 4'b0100; S = 4'b0100; R = 4'b0100; set_addr(0, 5, 0, 0);
      step();
      check("t4_gnt", 32'(gnt), 32'b0100);
      check("t4_q_hold", 32'(Q), 32'h20);
      check("t4_ill", 32'(illegal), 32'h1);
`ifdef SR_BANK_ERRCNT_EN
      check("t4_errcnt", 32'(err_cnt), 32'h1);
`endif
      req = 4'b0000; S = 4'b0000; R = 4'b0000;
      step();
      check("t4_ill_pulse", 32'(illegal), 32'h0);
      check("t4_gnt_off", 32'(gnt), 32'h0);

      // 5: preset with requester 1 pending, served afterwards
      req = 4'b0010; R = 4'b0010; set_addr(0, 0, 0, 0); PR = 1'b1;
      step();
      check("t5_pr_q", 32'(Q), 32'hFF);
      check("t5_pr_gnt", 32'(gnt), 32'h0);
      check("t5_pr_ill", 32'(illegal), 32'h0);
      PR = 1'b0;
      step();
      check("t5_gnt", 32'(gnt), 32'b0010);
      check("t5_q", 32'(Q), 32'hFE);
      req = 4'b0000; R = 4'b0000;

      // 6: ptr=2, req=1011 -> 3, 0, 1; then CLR resets ptr to 0
      req = 4'b1011; S = 4'b0000; R = 4'b0000;
      step(); check("t6_g3", 32'(gnt), 32'b1000); req = req & ~4'b1000;
      step(); check("t6_g0", 32'(gnt), 32'b0001); req = req & ~4'b0001;
      step(); check("t6_g1", 32'(gnt), 32'b0010); check("t6_q", 32'(Q), 32'hFE);
      req = 4'b1011; CLR = 1'b1;
      step();
      check("t6_clr_gnt", 32'(gnt), 32'h0);
      check("t6_clr_q", 32'(Q), 32'h00);
      check("t6_clr_busy", 32'(busy), 32'h0);
      CLR = 1'b0;
      step();
      check("t6_ptr0_gnt", 32'(gnt), 32'b0001);
      req = 4'b0000;
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
